// File: rtl/multi_clock_gen.sv
// multi_clock_gen
//   Multi-channel clock / PWM generator. Each channel divides clk by a
//   programmable period, drives its output high for a programmable number of
//   cycles at the start of each period, and starts counting from a
//   programmable phase on enable or sync. New settings are written into a
//   shadow copy and only moved into the active copy at a period boundary
//   (or while the channel is idle, or on sync), so a running output never
//   produces a runt or stretched pulse.
//
// Parameters
//   NCH : number of channels (1..16)
//   W   : width of period / high time / phase / counter
//   CW  : channel-select width
//
// Ports
//   clk        system clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   wr_en      one-cycle write strobe for a channel's shadow configuration
//   wr_ch      target channel; values >= NCH select nothing
//   wr_period  period in clk cycles (0 = channel off)
//   wr_high    high time in clk cycles
//   wr_phase   counter load value used on enable / sync
//   ch_en      per-channel run enable
//   sync       one-cycle pulse realigning every channel to its phase
//   clk_out    registered generated outputs
//   pend       shadow written but not yet applied
module multi_clock_gen #(
  parameter int NCH = 6,
  parameter int W   = 8,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en,
  input  logic [CW-1:0]  wr_ch,
  input  logic [W-1:0]   wr_period,
  input  logic [W-1:0]   wr_high,
  input  logic [W-1:0]   wr_phase,
  input  logic [NCH-1:0] ch_en,
  input  logic           sync,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] pend
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    // Active configuration (what the channel runs with right now)
    logic [W-1:0] per_a_reg;
    logic [W-1:0] hi_a_reg;
    logic [W-1:0] ph_a_reg;
    // Shadow configuration (last written, waiting for a boundary)
    logic [W-1:0] per_s_reg;
    logic [W-1:0] hi_s_reg;
    logic [W-1:0] ph_s_reg;
    logic [W-1:0] cnt_reg;
    logic         pend_reg;
    logic         out_reg;

    logic         wr_hit;
    logic         tc;
    logic         apply;
    logic [W-1:0] per_next;
    logic [W-1:0] hi_next;
    logic [W-1:0] ph_next;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt_next;

    always_comb begin
      // wr_ch can only equal gi when gi < NCH, so out-of-range channel
      // numbers never hit any channel.
      wr_hit = wr_en && (wr_ch == CW'(gi));

      // Terminal count: last cycle of the current period. Comparing against
      // per-1 keeps the counter below per, so it can never overflow.
      tc = ch_en[gi] && (per_a_reg != '0) && (cnt_reg == per_a_reg - W'(1));

      // Safe moments to switch configuration: end of period, channel idle
      // (disabled or off), or an explicit realignment.
      apply = pend_reg && (tc || !ch_en[gi] || (per_a_reg == '0) || sync);

      // Values that will be active after this edge; the shadow used here is
      // the pre-edge one, so a write on the same edge waits for the next
      // boundary.
      per_next = apply ? per_s_reg : per_a_reg;
      hi_next  = apply ? hi_s_reg  : hi_a_reg;
      ph_next  = apply ? ph_s_reg  : ph_a_reg;

      // A phase outside the period would never reach terminal count.
      load_val = (ph_next < per_next) ? ph_next : '0;

      if (per_next == '0) begin
        cnt_next = '0;
      end else if (!ch_en[gi] || sync) begin
        cnt_next = load_val;
      end else if (tc) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        per_a_reg <= '0;
        hi_a_reg  <= '0;
        ph_a_reg  <= '0;
        per_s_reg <= '0;
        hi_s_reg  <= '0;
        ph_s_reg  <= '0;
        cnt_reg   <= '0;
        pend_reg  <= 1'b0;
        out_reg   <= 1'b0;
      end else begin
        if (wr_hit) begin
          per_s_reg <= wr_period;
          hi_s_reg  <= wr_high;
          ph_s_reg  <= wr_phase;
        end
        per_a_reg <= per_next;
        hi_a_reg  <= hi_next;
        ph_a_reg  <= ph_next;
        cnt_reg   <= cnt_next;
        // A fresh write always wins over a simultaneous apply.
        pend_reg  <= wr_hit || (pend_reg && !apply);
        // High while the pre-edge count is below the high time. hi=0 gives
        // a constant 0 and hi>=per a constant 1 without special cases.
        out_reg   <= ch_en[gi] && (per_a_reg != '0) && (cnt_reg < hi_a_reg);
      end
    end

    assign clk_out[gi] = out_reg;
    assign pend[gi]    = pend_reg;
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Testbench for multi_clock_gen (NCH=6, W=8).
// Stimulus pushes hand-computed expected bits, tagged with the clock cycle in
// which they must be visible, into a scoreboard queue; an independent
// monitor compares and retires entries on every falling edge.
module tb_multi_clock_gen;

  localparam int NCH = 6;
  localparam int W   = 8;
  localparam int CW  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [CW-1:0]  wr_ch;
  logic [W-1:0]   wr_period;
  logic [W-1:0]   wr_high;
  logic [W-1:0]   wr_phase;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pend;

  multi_clock_gen #(.NCH(NCH), .W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_period (wr_period),
    .wr_high   (wr_high),
    .wr_phase  (wr_phase),
    .ch_en     (ch_en),
    .sync      (sync),
    .clk_out   (clk_out),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    ch;
    bit    is_pend;
    bit    val;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   finish_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc || finish_req) begin
        logic act;
        act = sb_q[i].is_pend ? pend[sb_q[i].ch] : clk_out[sb_q[i].ch];
        checks++;
        if (sb_q[i].cyc != cyc) begin
          errors++;
          $display("FAIL %s ch%0d: expectation for cycle %0d not checked in time (now %0d)",
                   sb_q[i].name, sb_q[i].ch, sb_q[i].cyc, cyc);
        end else if (act !== sb_q[i].val) begin
          errors++;
          $display("FAIL %s ch%0d %s cyc %0d: got %b expected %b",
                   sb_q[i].name, sb_q[i].ch, sb_q[i].is_pend ? "pend" : "clk_out",
                   cyc, act, sb_q[i].val);
        end else begin
          $display("ok   %s ch%0d %s cyc %0d = %b",
                   sb_q[i].name, sb_q[i].ch, sb_q[i].is_pend ? "pend" : "clk_out",
                   cyc, act);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expect a value k edges from now (k=0: the edge just passed).
  task automatic expect_bit(input int ch, input bit is_pend, input bit val,
                            input string name, input int k);
    exp_t e;
    e.cyc = cyc + k;
    e.ch = ch;
    e.is_pend = is_pend;
    e.val = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic expect_pat(input int ch, input bit is_pend, input string s,
                            input string name, input int k0);
    for (int j = 0; j < s.len(); j++)
      expect_bit(ch, is_pend, s[j] == "1", name, k0 + j);
  endtask

  task automatic expect_all_zero(input string name, input int k);
    for (int c = 0; c < NCH; c++) begin
      expect_bit(c, 1'b0, 1'b0, name, k);
      expect_bit(c, 1'b1, 1'b0, name, k);
    end
  endtask

  task automatic wr(input int ch, input int per, input int hi, input int ph);
    wr_en = 1'b1;
    wr_ch = CW'(ch);
    wr_period = W'(per);
    wr_high = W'(hi);
    wr_phase = W'(ph);
    tick();
    wr_en = 1'b0;
  endtask

  int    duty_hi[5];
  string duty_pat[5];

  initial begin
    duty_hi[0] = 0; duty_pat[0] = "000000000000";
    duty_hi[1] = 2; duty_pat[1] = "110000110000";
    duty_hi[2] = 5; duty_pat[2] = "111110111110";
    duty_hi[3] = 6; duty_pat[3] = "111111111111";
    duty_hi[4] = 9; duty_pat[4] = "111111111111";

    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_period = '0; wr_high = '0;
    wr_phase = '0; ch_en = '0; sync = 1'b0;
    tick(2);
    expect_all_zero("reset", 0);
    rst = 1'b0;
    tick();

    // Basic 3 high / 3 low on ch0, written while disabled.
    wr(0, 6, 3, 0);
    expect_bit(0, 1'b1, 1'b1, "t1_pend_set", 0);
    expect_bit(0, 1'b1, 1'b0, "t1_pend_clr", 1);
    tick();
    ch_en[0] = 1'b1;
    expect_pat(0, 1'b0, "111000111000", "t1_wave", 1);
    for (int c = 1; c < NCH; c++) expect_bit(c, 1'b0, 1'b0, "t1_others", 6);
    tick(12);

    // Duty sweep on ch1.
    for (int i = 0; i < 5; i++) begin
      ch_en[1] = 1'b0;
      wr(1, 6, duty_hi[i], 0);
      tick();
      ch_en[1] = 1'b1;
      expect_pat(1, 1'b0, duty_pat[i], $sformatf("t2_duty_hi%0d", duty_hi[i]), 1);
      tick(12);
    end

    // Glitch-free update on ch2: rewrite at cnt=2, applied at terminal count.
    wr(2, 6, 3, 0);
    tick();
    ch_en[2] = 1'b1;
    expect_pat(2, 1'b0, "111000100010", "t3_wave", 1);
    expect_pat(2, 1'b1, "0011100", "t3_pend", 1);
    tick(2);
    wr(2, 4, 1, 0);
    tick(9);

    // Phase and sync: ch3 ph=0, ch4 ph=4, both per=8 hi=4.
    wr(3, 8, 4, 0);
    wr(4, 8, 4, 4);
    tick();
    ch_en[3] = 1'b1;
    ch_en[4] = 1'b1;
    sync = 1'b1;
    expect_pat(3, 1'b0, "11111000011110000", "t4_ch3", 1);
    expect_pat(4, 1'b0, "00000111100001111", "t4_ch4", 1);
    tick();
    sync = 1'b0;
    tick(16);

    // ph=9 with per=8 loads 0, so sync brings ch4 into step with ch3.
    wr(4, 8, 4, 9);
    expect_bit(4, 1'b1, 1'b1, "t4_pend_ph9", 0);
    sync = 1'b1;
    expect_bit(4, 1'b1, 1'b0, "t4_pend_sync", 1);
    expect_pat(3, 1'b0, "11110000", "t4_align3", 2);
    expect_pat(4, 1'b0, "11110000", "t4_ph9", 2);
    tick();
    sync = 1'b0;
    tick(9);

    // Collision on ch5: second write lands on the edge that applies the first.
    wr(5, 4, 2, 0);
    tick();
    ch_en[5] = 1'b1;
    expect_pat(5, 1'b0, "1100101110001", "t5_wave", 1);
    expect_pat(5, 1'b1, "0111100", "t5_pend", 1);
    tick();
    wr(5, 2, 1, 0);
    tick();
    wr(5, 6, 3, 0);
    tick(9);

    // Out-of-range channel write changes nothing.
    wr(6, 1, 1, 0);
    for (int c = 0; c < NCH; c++) expect_bit(c, 1'b1, 1'b0, "t6_range", 0);
    expect_pat(1, 1'b0, "111", "t6_ch1_run", 1);
    tick(3);

    // Reset mid-operation, overriding wr_en / sync / ch_en.
    ch_en = '1;
    wr(2, 5, 2, 0);
    expect_bit(2, 1'b1, 1'b1, "t7_pend_before", 0);
    rst = 1'b1;
    sync = 1'b1;
    wr_en = 1'b1;
    wr_ch = 3'd1;
    wr_period = 8'd4;
    wr_high = 8'd2;
    wr_phase = 8'd0;
    tick();
    expect_all_zero("t7_reset", 0);
    rst = 1'b0;
    sync = 1'b0;
    wr_en = 1'b0;
    expect_all_zero("t7_after", 1);
    expect_all_zero("t7_after", 3);
    tick(4);

    finish_req = 1'b1;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
